fp_resp_buf: RTL
================

FP_RESP_BUF -- requirements
Module: fp_resp_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning response FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning maximum cycles an operation may stay outstanding.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port req_valid  input  1  issuer has an operation ready for fp_unit.
REQ-006 SHALL have port req_enable  output  1  fp_exe enable to fp_unit; the operation is issued this cycle.
REQ-007 SHALL have port exe_ready  input  1  fp_exe ready from fp_unit.
REQ-008 SHALL have port exe_result  input  64  fp_exe result.
REQ-009 SHALL have port exe_flags  input  5  fp_exe flags {NV,DZ,OF,UF,NX}.
REQ-010 SHALL have port out_valid  output  1  head FIFO entry is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-012 SHALL have port out_result  output  64  head entry result.
REQ-013 SHALL have port out_flags  output  5  head entry flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 SHALL have port busy  output  1  one operation is outstanding.
REQ-016 SHALL have port err_spurious  output  1  sticky; exe_ready seen while not BUSY.
REQ-017 SHALL have port err_timeout  output  1  sticky; watchdog expired (FP_RESP_TIMEOUT_EN only, else tied 0).

Function
REQ-018 SHALL implement FSM states IDLE and BUSY, with busy = (state==BUSY).
REQ-019 SHALL define space = (count + busy - (out_valid & out_ready)) < DEPTH, reserving a FIFO slot for every outstanding operation.
REQ-020 SHALL drive req_enable = req_valid & space & (IDLE | (BUSY & exe_ready)), combinationally, so back-to-back issue is allowed in the completion cycle.
REQ-021 SHALL transition IDLE->BUSY on req_enable.
REQ-022 SHALL, in BUSY with exe_ready, push {exe_result, exe_flags} and go to IDLE, or stay in BUSY if req_enable is also high.
REQ-023 SHALL ignore exe_ready in IDLE (no push) and set err_spurious.
REQ-024 SHALL provide a first-word-fall-through FIFO: out_valid = (count != 0), out_result/out_flags = head entry, with a pop on out_valid & out_ready.
REQ-025 SHALL make a pushed entry visible on out_* the cycle after exe_ready, with no same-cycle bypass.
REQ-026 SHALL, on simultaneous push and pop, leave count unchanged and keep the entry order correct, including at count==DEPTH-1 and with pointer wrap-around.
REQ-027 SHALL never push while full; by construction of REQ-019, overflow is unreachable.
REQ-028 SHALL make out_ready while empty a no-op.
REQ-029 SHALL keep out_result/out_flags stable while out_valid & ~out_ready.

Reset
REQ-030 SHALL, while reset==0 at a clock edge, set state=IDLE, pointers=0, count=0, out_valid=0, busy=0, err_spurious=0, err_timeout=0, and watchdog=0.
REQ-031 SHALL drive out_result/out_flags to 0 while empty after reset.
REQ-032 SHALL hold req_enable at 0 during reset.
REQ-033 SHALL, on reset mid-operation, discard the outstanding operation and all FIFO contents, so that a late exe_ready after reset sets err_spurious.

Configuration
REQ-034 SHALL, with FP_RESP_TIMEOUT_EN defined, count cycles in BUSY; when the count reaches TIMEOUT without exe_ready, set err_timeout, return to IDLE, and release the reserved slot with no push.
REQ-035 SHALL, with FP_RESP_TIMEOUT_EN defined, clear the watchdog on each issue.
REQ-036 SHALL, without FP_RESP_TIMEOUT_EN, omit the watchdog counter, tie err_timeout to 0, and hold BUSY indefinitely.

Structure
REQ-037 SHALL place the typedef fp_resp_entry_type {result[63:0], flags[4:0]} and the FSM state enum in package fp_wire.
REQ-038 SHALL instantiate one sub-module, fp_resp_fifo (parameter DEPTH, push/pop/full/empty/count), containing the storage and pointers; the FSM, credit logic and watchdog SHALL stay in fp_resp_buf.

Verification
REQ-039 SHALL cover single op: req_valid=1 for one cycle -> req_enable=1; exe_ready 3 cycles later with result 0x000000003F800000, flags 00000 -> out_valid next cycle, out_result=0x3F800000, count=1.
REQ-040 SHALL cover back-to-back: req_valid held, out_ready=1, exe_ready every 2nd cycle -> req_enable pulses in each exe_ready cycle; outputs in order; count never exceeds 1.
REQ-041 SHALL cover backpressure: DEPTH=4, out_ready=0, 4 ops complete -> count=4, req_enable stays 0 with req_valid=1; one pop -> req_enable=1 the same cycle.
REQ-042 SHALL cover wrap: 10 ops with out_ready toggling 1010 and simultaneous push/pop at count=3 -> FIFO order preserved, flags 00001 and 10000 returned intact.
REQ-043 SHALL cover spurious/reset: exe_ready in IDLE -> err_spurious=1, count=0; reset asserted while BUSY with count=2 -> all outputs 0 next cycle.
REQ-044 SHALL cover timeout (FP_RESP_TIMEOUT_EN, TIMEOUT=8): issue with no exe_ready -> err_timeout=1 after 8 BUSY cycles, busy=0, count unchanged.

Source files
------------

// File: rtl/fp_resp_buf_pkg.sv
// Shared types for the FP response buffer: FIFO entry layout and control FSM states.
package fp_wire;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
  } fp_resp_entry_type;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fp_resp_state_type;

endpackage

// File: rtl/fp_resp_buf_fifo.sv
// First-word-fall-through response FIFO; entry storage is not reset, head reads 0 while empty.
module fp_resp_fifo
  import fp_wire::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  fp_resp_entry_type       din,
  output fp_resp_entry_type       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fp_resp_entry_type mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop & ~empty;
  assign dout   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fp_resp_buf.sv
// Credit-checked issue/response buffer between an FP issuer and fp_unit.
// Optional watchdog enabled by defining FP_RESP_TIMEOUT_EN.
module fp_resp_buf
  import fp_wire::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    reset,
  input  logic                    clock,
  input  logic                    req_valid,
  output logic                    req_enable,
  input  logic                    exe_ready,
  input  logic [63:0]             exe_result,
  input  logic [4:0]              exe_flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_result,
  output logic [4:0]              out_flags,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy,
  output logic                    err_spurious,
  output logic                    err_timeout
);

  localparam int CW = $clog2(DEPTH) + 1;

  fp_resp_state_type state;
  fp_resp_entry_type push_entry;
  fp_resp_entry_type head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              space;
  logic              timeout_hit;
  logic [CW:0]       need;

  assign busy      = (state == BUSY);
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign push      = busy & exe_ready & ~fifo_full;

  // Occupancy including the slot reserved for the outstanding operation.
  assign need  = {1'b0, count} + {{CW{1'b0}}, busy} - {{CW{1'b0}}, pop};
  assign space = (need < (CW + 1)'(DEPTH));

  assign req_enable = reset & req_valid & space & (~busy | exe_ready);

  assign push_entry.result = exe_result;
  assign push_entry.flags  = exe_flags;
  assign out_result        = head_entry.result;
  assign out_flags         = head_entry.flags;

  fp_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

`ifdef FP_RESP_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wdog;

  assign timeout_hit = busy & ~exe_ready & (wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (req_enable)
        wdog <= '0;
      else if (busy)
        wdog <= wdog + 1'b1;
      if (timeout_hit)
        err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      err_spurious <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exe_ready)
            err_spurious <= 1'b1;
          if (req_enable)
            state <= BUSY;
        end
        BUSY: begin
          if (exe_ready)
            state <= req_enable ? BUSY : IDLE;
          else if (timeout_hit)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
